// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// queue depth and the per-instruction byte stride.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_QUEUE_DEPTH = 2;
  localparam int unsigned INSTR_STRIDE      = 4;
  localparam int unsigned COUNT_W           = $clog2(FETCH_QUEUE_DEPTH + 1);

  localparam logic [COUNT_W-1:0] QUEUE_FULL = COUNT_W'(FETCH_QUEUE_DEPTH);

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instruction} queue with push, pop and flush. The head slot
// is always slot 0, so the head outputs come straight from flops.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_instr,
  output logic [COUNT_W-1:0]    count,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_instr
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  entry_t               slot_q [FETCH_QUEUE_DEPTH];
  entry_t               slot_d [FETCH_QUEUE_DEPTH];
  entry_t               in_entry;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 do_push, do_pop;

  assign in_entry = '{pc: push_pc, instr: push_instr};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    slot_d  = slot_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != QUEUE_FULL) || do_pop);

    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          slot_d[count_q[0]] = in_entry;
          count_d            = count_q + COUNT_W'(1);
        end
        2'b01: begin
          slot_d[0] = slot_q[1];
          count_d   = count_q - COUNT_W'(1);
        end
        2'b11: begin
          // Simultaneous push and pop: the new entry lands behind whatever survives the pop.
          if (count_q == QUEUE_FULL) begin
            slot_d[0] = slot_q[1];
            slot_d[1] = in_entry;
          end else begin
            slot_d[0] = in_entry;
          end
        end
        default: ;
      endcase
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      // NOTE: the slots are reset (unlike a general memory) so the head reads zero out of reset.
      for (int i = 0; i < FETCH_QUEUE_DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign count      = count_q;
  assign head_valid = valid_q;
  assign head_pc    = slot_q[0].pc;
  assign head_instr = slot_q[0].instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through program memory into a
// 2-entry queue. Define FETCH_BOUNDS_CHECK_EN to trap fetches past MEMORY_DEPTH.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] pc_address,
  input  logic [DATA_WIDTH-1:0] mem_instruction,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  fetch_fault
);

  localparam logic [DATA_WIDTH-1:0] STRIDE     = DATA_WIDTH'(INSTR_STRIDE);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(INSTR_STRIDE - 1);

  if (MEMORY_DEPTH < 1 || DATA_WIDTH < 3) begin : g_bad_params
    $error("fetch_sequencer: MEMORY_DEPTH must be >= 1 and DATA_WIDTH >= 3");
  end

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [COUNT_W-1:0]    count;
  logic                  push, pop, flush, room, out_of_range;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [DATA_WIDTH-3:0] DEPTH_WORDS = (DATA_WIDTH-2)'(MEMORY_DEPTH);

  assign out_of_range = (pc_q[DATA_WIDTH-1:2] >= DEPTH_WORDS);
  assign fetch_fault  = (state_q == FAULT);
`else
  assign out_of_range = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  // A redirect cancels the pop as well as the push: the flushed head is never consumed.
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign room = (count != QUEUE_FULL) || pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;

    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_target & ALIGN_MASK;
      state_d = halt ? STALL : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (halt) begin
            state_d = STALL;
          end else if (room) begin
            if (out_of_range) begin
              state_d = FAULT;
            end else begin
              push = 1'b1;
              pc_d = pc_q + STRIDE;
            end
          end
        end
        STALL: begin
          if (!halt) state_d = FETCH;
        end
        FAULT: ;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_address = pc_q;

  fetch_queue #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_pc    (pc_q),
    .push_instr (mem_instruction),
    .count      (count),
    .head_valid (instr_valid),
    .head_pc    (instr_pc),
    .head_instr (instr_data)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by random
// halt/ready/redirect traffic, checked against a queue-based reference model.
module tb_fetch_sequencer;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
  localparam int DEPTH  = 4;
`else
  localparam bit BOUNDS = 1'b0;
  localparam int DEPTH  = 32;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic [31:0] mem_instruction;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .MEMORY_DEPTH (DEPTH),
    .DATA_WIDTH   (32),
    .RESET_PC     (RST_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_address      (pc_address),
    .mem_instruction (mem_instruction),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  // Program memory contents: a distinct, non-zero word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign mem_instruction = mem_word(pc_address);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: expected queue contents, next fetch address and mode.
  typedef enum {RUNNING, STALLED, FAULTED} mode_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  item_t       got;
  logic [31:0] m_pc;
  mode_e       m_mode;
  logic [31:0] last_pc = '0;

  function automatic void model_reset();
    exp_q.delete();
    m_pc   = RST_PC;
    m_mode = RUNNING;
  endfunction

  // Applied once per clock edge with the inputs that were held across it;
  // any pop for this edge has already been taken by the monitor.
  function automatic void model_edge();
    item_t it;
    if (redirect_valid) begin
      exp_q.delete();
      m_pc   = redirect_target & 32'hFFFF_FFFC;
      m_mode = halt ? STALLED : RUNNING;
    end else if (m_mode == STALLED) begin
      if (!halt) m_mode = RUNNING;
    end else if (m_mode == RUNNING) begin
      if (halt) begin
        m_mode = STALLED;
      end else if (exp_q.size() < 2) begin
        if (BOUNDS && ((m_pc >> 2) >= 32'(DEPTH))) begin
          m_mode = FAULTED;
        end else begin
          it.pc    = m_pc;
          it.instr = mem_word(m_pc);
          exp_q.push_back(it);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endfunction

  // Monitor: samples mid-cycle, scores every head the consumer will accept.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc   = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_pc_address", pc_address, RST_PC);
      check("rst_instr_data", instr_data, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_fault", {31'b0, fetch_fault}, 32'd0);
      prev_hold = 1'b0;
    end else begin
      check("valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
      check("pc_address", pc_address, m_pc);
      check("fault", {31'b0, fetch_fault}, {31'b0, m_mode == FAULTED});
      if (prev_hold) begin
        check("hold_pc", instr_pc, prev_pc);
        check("hold_data", instr_data, prev_data);
      end
      if (exp_q.size() != 0 && instr_ready && !redirect_valid) begin
        got = exp_q.pop_front();
        check("head_pc", instr_pc, got.pc);
        check("head_data", instr_data, got.instr);
        last_pc = got.pc;
      end
      prev_hold = instr_valid && !instr_ready && !redirect_valid;
      prev_pc   = instr_pc;
      prev_data = instr_data;
    end
  end

  task automatic step(input logic h, input logic r, input logic rv, input logic [31:0] tgt);
    halt            = h;
    instr_ready     = r;
    redirect_valid  = rv;
    redirect_target = tgt;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [31:0] rand_tgt;

  initial begin
    halt            = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    do_reset();

    // Streaming from reset: one instruction per edge.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("stream_pc", pc_address, 32'h18);
    check("stream_head", instr_pc, 32'h14);
    check("stream_valid", {31'b0, instr_valid}, 32'd1);

    // Consumer stalled: queue fills to two, PC stops at 8.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("full_pc", pc_address, 32'h8);
    check("full_head", instr_pc, 32'h0);
    check("full_valid", {31'b0, instr_valid}, 32'd1);

    // Halt for three edges: queue drains, PC frozen, fetch resumes at 8.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("halt_pc", pc_address, 32'h8);
    check("halt_drained", {31'b0, instr_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("halt_exit_valid", {31'b0, instr_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("resume_valid", {31'b0, instr_valid}, 32'd1);
    check("resume_pc", instr_pc, 32'h8);

`ifdef FETCH_BOUNDS_CHECK_EN
    // Fetch runs off the end of a 4-word memory.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("oob_fault", {31'b0, fetch_fault}, 32'd1);
    check("oob_pc", pc_address, 32'h10);
    check("oob_last_pc", last_pc, 32'h0C);
    check("oob_valid", {31'b0, instr_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    check("oob_cleared", {31'b0, fetch_fault}, 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("oob_refetch_valid", {31'b0, instr_valid}, 32'd1);
    check("oob_refetch_pc", instr_pc, 32'h0);
`else
    // Redirect to an unaligned target while the queue is full.
    step(1'b0, 1'b0, 1'b0, '0);
    check("redir_full_valid", {31'b0, instr_valid}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h43);
    check("redir_flush_valid", {31'b0, instr_valid}, 32'd0);
    check("redir_pc", pc_address, 32'h40);
    step(1'b0, 1'b1, 1'b0, '0);
    check("redir_head_valid", {31'b0, instr_valid}, 32'd1);
    check("redir_head_pc", instr_pc, 32'h40);

    // PC wraps through the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("wrap_pc", pc_address, 32'h4);
    check("wrap_head", instr_pc, 32'h0);
`endif

    // Reset mid-stream with a full queue.
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("pre_rst_pc", pc_address, 32'h8);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_pc", pc_address, RST_PC);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_tgt = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 4 * DEPTH + 8);
      step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 5, rand_tgt);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
